// File: rtl/stopwatch_lap_timer.sv
// Stopwatch/lap timer core: BCD mm..m:ss.cc count, up/down, run/pause, lap freeze, preset, terminal detect.
// Latency: count changes on the step edge; disp_bcd and tick/done/overflow follow one clock later.
// Backpressure: none; control inputs are single-cycle pulses acted on in the cycle they arrive.
module stopwatch_lap_timer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int MIN_DIGITS  = 1,
  parameter int WRAP        = 0
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        start_stop,
  input  logic                        lap,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        count_down,
  input  logic [4*(4+MIN_DIGITS)-1:0] preset_bcd,
  output logic [4*(4+MIN_DIGITS)-1:0] disp_bcd,
  output logic                        running,
  output logic                        lap_hold,
  output logic                        tick,
  output logic                        done,
  output logic                        overflow
);
  localparam int ND  = 4 + MIN_DIGITS;
  localparam int W   = 4 * ND;
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  count, snap, cnt_inc, cnt_dec, cnt_clamp;
  logic [PW-1:0] presc;
  logic          dir, step_q, done_q, ovf_q;
  logic          inc_carry, dec_borrow;
  logic          step, at_max, count_zero, term, start_ok, load_ok, lap_ok;

  // Seconds-tens digit (index 3) runs 0-5; every other digit runs 0-9.
  function automatic logic [3:0] dig_max(input int i);
    return (i == 3) ? 4'd5 : 4'd9;
  endfunction

  // Ripple BCD increment/decrement and per-digit preset clamp.
  always_comb begin
    cnt_inc    = count;
    cnt_dec    = count;
    cnt_clamp  = preset_bcd;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (inc_carry) begin
        if (count[4*i +: 4] >= dig_max(i)) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = dig_max(i);
        end else begin
          cnt_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
      if (preset_bcd[4*i +: 4] > dig_max(i)) cnt_clamp[4*i +: 4] = dig_max(i);
    end
  end

  // Step/terminal qualifiers shared by the FSM and the datapath.
  always_comb begin
    at_max     = inc_carry;
    count_zero = (count == '0);
    step       = (state == RUNNING) && (presc == PRESC_LAST);
    term       = dir ? (count_zero || (cnt_dec == '0)) : (at_max && (WRAP == 0));
    start_ok   = !(count_down && count_zero);
    load_ok    = load && (state != RUNNING);
    lap_ok     = lap && !start_stop && ((state == RUNNING) || (state == PAUSED)) && !(step && term);
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: clear > load > start_stop; a terminal step beats a same-cycle pause.
  always_comb begin
    state_nxt = state;
    if (clear || load_ok) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop && start_ok) state_nxt = RUNNING;
        RUNNING: begin
          if (step && term)    state_nxt = DONE;
          else if (start_stop) state_nxt = PAUSED;
        end
        PAUSED:  if (start_stop) state_nxt = RUNNING;
        default: state_nxt = state;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    running = (state == RUNNING);
  end

  // Count, prescaler, direction latch, lap snapshot and the registered display/pulses.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count    <= '0;
      snap     <= '0;
      presc    <= '0;
      dir      <= 1'b0;
      lap_hold <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      disp_bcd <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (clear) begin
        count    <= '0;
        presc    <= '0;
        lap_hold <= 1'b0;
      end else if (load_ok) begin
        count    <= cnt_clamp;
        presc    <= '0;
        lap_hold <= 1'b0;
      end else begin
        if ((state == IDLE) && start_stop && start_ok) dir <= count_down;
        if (state == RUNNING) begin
          if (step) begin
            presc  <= '0;
            // A saturating up step leaves the count unchanged, so it is not a tick.
            step_q <= dir || !term;
            if (term) lap_hold <= 1'b0;
            if (dir) begin
              count  <= term ? '0 : cnt_dec;
              done_q <= term;
            end else if (at_max) begin
              if (WRAP != 0) begin
                count <= '0;
                ovf_q <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end else begin
              count <= cnt_inc;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        if (lap_ok) begin
          if (!lap_hold) begin
            lap_hold <= 1'b1;
            snap     <= count;
          end else begin
            lap_hold <= 1'b0;
          end
        end
      end
      disp_bcd <= lap_hold ? snap : count;
      tick     <= step_q;
      done     <= done_q;
      overflow <= ovf_q;
    end
  end
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: two instances (saturate / wrap) share stimulus; a queue of
// expected displays is filled as stimulus is applied and drained on each output pulse.
module tb_stopwatch_lap_timer;
  localparam int W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         Reset, start_stop, lap, clear, load, count_down;
  logic [W-1:0] preset_bcd;
  logic [W-1:0] d0_disp, d1_disp;
  logic         d0_running, d0_lap_hold, d0_tick, d0_done, d0_overflow;
  logic         d1_running, d1_lap_hold, d1_tick, d1_done, d1_overflow;
  logic         d0_ev;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           nev = 0;
  int           t_evt = 0;
  int           t_stim = 0;
  string        phase = "init";
  logic [W-1:0] exp_q[$];

  assign d0_ev = d0_tick | d0_done | d0_overflow;

  stopwatch_lap_timer #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .MIN_DIGITS(1), .WRAP(0)) dut0 (
    .clk(clk), .Reset(Reset), .start_stop(start_stop), .lap(lap), .clear(clear), .load(load),
    .count_down(count_down), .preset_bcd(preset_bcd), .disp_bcd(d0_disp), .running(d0_running),
    .lap_hold(d0_lap_hold), .tick(d0_tick), .done(d0_done), .overflow(d0_overflow));

  stopwatch_lap_timer #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .MIN_DIGITS(1), .WRAP(1)) dut1 (
    .clk(clk), .Reset(Reset), .start_stop(start_stop), .lap(lap), .clear(clear), .load(load),
    .count_down(count_down), .preset_bcd(preset_bcd), .disp_bcd(d1_disp), .running(d1_running),
    .lap_hold(d1_lap_hold), .tick(d1_tick), .done(d1_done), .overflow(d1_overflow));

  always @(posedge clk) cyc <= cyc + 1;

  // Hundredths of a second -> m:ss.cc BCD.
  function automatic logic [W-1:0] to_bcd(input int h);
    int cs, s, m;
    cs = h % 100;
    s  = (h / 100) % 60;
    m  = h / 6000;
    return {4'(m), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; on any output pulse, compare the display with the next expected value.
  task automatic step1();
    @(negedge clk);
    if (d0_ev) begin
      nev++;
      t_evt = cyc;
      if (exp_q.size() > 0) check({phase, "_sb_disp"}, 32'(d0_disp), 32'(exp_q.pop_front()));
      else check({phase, "_sb_unexpected_event"}, 32'(d0_ev), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step1();
  endtask

  task automatic wait_evt(input int limit);
    int start_n;
    int n;
    start_n = nev;
    n = 0;
    while (nev == start_n && n < limit) begin
      step1();
      n++;
    end
    check({phase, "_evt_timeout"}, 32'(nev != start_n), 32'd1);
  endtask

  // One-cycle pulse on the selected controls; t_stim is the edge that samples it.
  task automatic pulse(input logic ss, input logic lp, input logic clr, input logic ld);
    start_stop = ss; lap = lp; clear = clr; load = ld;
    step1();
    t_stim = cyc;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int t0, tr, prev, lat_start, ev0;
    Reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; load = 1'b0;
    count_down = 1'b0; preset_bcd = '0;

    phase = "reset";
    repeat (3) @(negedge clk);
    check("reset_disp0", 32'(d0_disp), 32'd0);
    check("reset_disp1", 32'(d1_disp), 32'd0);
    check("reset_flags0", 32'({d0_running, d0_lap_hold, d0_tick, d0_done, d0_overflow}), 32'd0);
    Reset = 1'b0;
    idle(2);

    // Up count: 10 ticks, one every 10 clocks, ending on 0:00.10.
    phase = "up";
    for (int i = 1; i <= 10; i++) exp_q.push_back(to_bcd(i));
    pulse(1, 0, 0, 0);
    t0 = t_stim;
    wait_evt(40);
    lat_start = t_evt - t0;
    prev = t_evt;
    for (int i = 2; i <= 10; i++) begin
      wait_evt(40);
      check("up_tick_interval", 32'(t_evt - prev), 32'd10);
      prev = t_evt;
    end
    check("up_disp_0_00_10", 32'(d0_disp), 32'h00010);
    check("up_running", 32'(d0_running), 32'd1);
    step1();
    check("up_tick_one_cycle", 32'(d0_tick), 32'd0);
    pulse(0, 0, 1, 0);
    idle(2);
    check("clear_disp", 32'(d0_disp), 32'd0);
    check("clear_running", 32'(d0_running), 32'd0);

    // Pause at clk 35, hold 50 clocks, resume keeps the partial interval.
    phase = "pause";
    for (int i = 1; i <= 3; i++) exp_q.push_back(to_bcd(i));
    pulse(1, 0, 0, 0);
    t0 = t_stim;
    for (int i = 0; i < 3; i++) wait_evt(40);
    while (cyc < t0 + 34) step1();
    pulse(1, 0, 0, 0);
    ev0 = nev;
    idle(50);
    check("pause_no_tick", 32'(nev - ev0), 32'd0);
    check("pause_hold_disp", 32'(d0_disp), 32'h00003);
    check("pause_running", 32'(d0_running), 32'd0);
    exp_q.push_back(to_bcd(4));
    exp_q.push_back(to_bcd(5));
    pulse(1, 0, 0, 0);
    tr = t_stim;
    wait_evt(40);
    check("resume_5_clks_short", 32'(lat_start - (t_evt - tr)), 32'd5);
    prev = t_evt;
    wait_evt(40);
    check("resume_interval", 32'(t_evt - prev), 32'd10);

    // Lap: freeze at 0:01.00, count on underneath, release at 0:01.20.
    phase = "lap";
    for (int i = 6; i <= 100; i++) exp_q.push_back(to_bcd(i));
    for (int i = 6; i <= 100; i++) wait_evt(40);
    pulse(0, 1, 0, 0);
    step1();
    check("lap_hold_set", 32'(d0_lap_hold), 32'd1);
    check("lap_frozen_disp", 32'(d0_disp), 32'h00100);
    for (int i = 0; i < 20; i++) exp_q.push_back(20'h00100);
    for (int i = 0; i < 20; i++) wait_evt(40);
    check("lap_still_running", 32'(d0_running), 32'd1);
    pulse(0, 1, 0, 0);
    step1();
    check("lap_hold_clear", 32'(d0_lap_hold), 32'd0);
    check("lap_release_disp", 32'(d0_disp), 32'h00120);

    // Down count to zero, done pulse, DONE ignores start_stop.
    phase = "down";
    pulse(0, 0, 1, 0);
    count_down = 1'b1;
    preset_bcd = 20'h00005;
    pulse(0, 0, 0, 1);
    step1();
    check("down_load_disp", 32'(d0_disp), 32'h00005);
    for (int i = 4; i >= 0; i--) exp_q.push_back(to_bcd(i));
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      wait_evt(40);
      check("down_done_flag", 32'(d0_done), 32'(i == 4));
    end
    check("down_done_state", 32'(d0_running), 32'd0);
    step1();
    check("down_done_one_cycle", 32'(d0_done), 32'd0);
    pulse(1, 0, 0, 0);
    idle(20);
    check("done_ignores_start_run", 32'(d0_running), 32'd0);
    check("done_ignores_start_disp", 32'(d0_disp), 32'd0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    idle(3);
    check("idle_zero_down_start_ignored", 32'(d0_running), 32'd0);

    // Borrow across the minute boundary.
    phase = "borrow";
    preset_bcd = 20'h10000;
    pulse(0, 0, 0, 1);
    exp_q.push_back(20'h05999);
    pulse(1, 0, 0, 0);
    wait_evt(40);
    pulse(0, 0, 1, 0);
    count_down = 1'b0;

    // Up limit: saturate (dut0) vs wrap (dut1).
    phase = "limit";
    preset_bcd = 20'h95999;
    pulse(0, 0, 0, 1);
    exp_q.push_back(20'h95999);
    pulse(1, 0, 0, 0);
    wait_evt(40);
    check("limit_sat_done", 32'(d0_done), 32'd1);
    check("limit_sat_running", 32'(d0_running), 32'd0);
    check("limit_wrap_overflow", 32'(d1_overflow), 32'd1);
    check("limit_wrap_disp", 32'(d1_disp), 32'd0);
    check("limit_wrap_running", 32'(d1_running), 32'd1);
    pulse(0, 0, 1, 0);
    idle(2);

    // Priority, clamp, load-while-running, asynchronous reset.
    phase = "prio";
    preset_bcd = 20'h12345;
    pulse(1, 0, 1, 1);
    idle(2);
    check("prio_clear_running", 32'(d0_running), 32'd0);
    check("prio_clear_disp", 32'(d0_disp), 32'd0);
    preset_bcd = 20'hFAFFF;
    pulse(0, 0, 0, 1);
    step1();
    check("clamp_disp", 32'(d0_disp), 32'h95999);
    pulse(0, 0, 1, 0);
    exp_q.push_back(20'h00001);
    pulse(1, 0, 0, 0);
    idle(2);
    preset_bcd = 20'h55555;
    pulse(0, 0, 0, 1);
    idle(1);
    check("load_running_ignored_run", 32'(d0_running), 32'd1);
    wait_evt(40);
    idle(3);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_d0", 32'({d0_disp, d0_running, d0_lap_hold, d0_tick, d0_done, d0_overflow}), 32'd0);
    check("async_reset_d1", 32'({d1_disp, d1_running, d1_lap_hold, d1_tick, d1_done, d1_overflow}), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    idle(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
